// File: rtl/memory_stage_issue.sv
// memory_stage_issue: decode handshake stage running a timed request/ack bus cycle for LOAD/STORE
module memory_stage_issue #(
  parameter logic [4:0] OPC_NOP = 5'h00,
  parameter logic [4:0] OPC_LOAD = 5'h01,
  parameter logic [4:0] OPC_STORE = 5'h02,
  parameter logic [4:0] OPC_ALUM = 5'h03,
  parameter logic [4:0] OPC_ALU = 5'h04,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        bus_req,
  output logic        bus_read,
  output logic        bus_write,
  output logic [1:0]  bus_width,
  input  logic        bus_ack,
  output logic        fetch_block,
  output logic        timeout_error,
  output logic [3:0]  reg_address_index,
  output logic [3:0]  reg_data_index,
  output logic [3:0]  reg_operand_index,
  output logic [4:0]  alu_op
);
  localparam int CW = TIMEOUT_CYCLES < 1 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0] held;
  logic [4:0] op;
  logic is_read, accept, is_mem, ack, tmo;
  assign op = in_instruction[31:27];
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign is_mem = op == OPC_LOAD || op == OPC_STORE;
  assign ack = state == BUS && bus_ack;
  assign tmo = state == BUS && !bus_ack && TIMEOUT_CYCLES != 0 && int'(cnt) == TIMEOUT_CYCLES - 1;
  assign bus_req = state == BUS;
  assign fetch_block = bus_req;
  assign bus_read = bus_req && is_read;
  assign bus_write = bus_req && !is_read;
  always_comb
    state_next = state == IDLE ? (accept && is_mem ? BUS : IDLE) : (ack || tmo ? IDLE : BUS);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_instruction <= {OPC_NOP, 27'h0};
      timeout_error <= 1'b0;
      bus_width <= 2'b00;
      reg_address_index <= 4'h0;
      reg_data_index <= 4'h0;
      reg_operand_index <= 4'h0;
      alu_op <= 5'h00;
      cnt <= '0;
      held <= 32'h0;
      is_read <= 1'b0;
    end else begin
      timeout_error <= tmo;
      if (accept) begin
        bus_width <= in_instruction[26:25];
        reg_data_index <= in_instruction[23:20];
        reg_address_index <= in_instruction[19:16];
        reg_operand_index <= in_instruction[11:8];
        if (op == OPC_ALU || op == OPC_ALUM) alu_op <= {op == OPC_ALU, in_instruction[15:12]};
        held <= in_instruction;
        is_read <= op == OPC_LOAD;
        cnt <= '0;
      end
      if (state == BUS) cnt <= &cnt ? cnt : cnt + CW'(1);
      if (accept && !is_mem) begin
        out_valid <= 1'b1;
        out_instruction <= in_instruction;
      end else if (ack) begin
        out_valid <= 1'b1;
        out_instruction <= held;
      end else if (tmo) begin
        out_valid <= 1'b1;
        out_instruction <= {OPC_NOP, 27'h0};
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_memory_stage_issue.sv
// tb_memory_stage_issue: directed self-checking bench for memory_stage_issue with a 4-cycle timeout
module tb_memory_stage_issue;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, bus_ack = 1'b0;
  logic [31:0] in_instruction = 32'h0;
  logic in_ready, out_valid, bus_req, bus_read, bus_write, fetch_block, timeout_error;
  logic [31:0] out_instruction;
  logic [1:0] bus_width;
  logic [3:0] reg_address_index, reg_data_index, reg_operand_index;
  logic [4:0] alu_op;
  int checks = 0, errors = 0;
  memory_stage_issue #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .bus_req(bus_req), .bus_read(bus_read),
    .bus_write(bus_write), .bus_width(bus_width), .bus_ack(bus_ack),
    .fetch_block(fetch_block), .timeout_error(timeout_error),
    .reg_address_index(reg_address_index), .reg_data_index(reg_data_index),
    .reg_operand_index(reg_operand_index), .alu_op(alu_op)
  );
  always #5 clock = ~clock;
  task automatic test_reset;
    @(negedge clock);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_instruction !== 32'h0) begin errors++; $display("FAIL reset_out_instruction got %h exp 00000000", out_instruction); end
    checks++; if ({bus_req, bus_read, bus_write, fetch_block, timeout_error} !== 5'b0) begin errors++; $display("FAIL reset_bus got %b exp 00000", {bus_req, bus_read, bus_write, fetch_block, timeout_error}); end
    checks++; if ({bus_width, reg_address_index, reg_data_index, reg_operand_index, alu_op} !== 19'h0) begin errors++; $display("FAIL reset_fields got %h exp 0", {bus_width, reg_address_index, reg_data_index, reg_operand_index, alu_op}); end
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_alu;
    in_valid = 1'b1; in_instruction = 32'h2000_A300; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_out_valid got %b exp 1", out_valid); end
    checks++; if (out_instruction !== 32'h2000_A300) begin errors++; $display("FAIL alu_out_instruction got %h exp 2000a300", out_instruction); end
    checks++; if (alu_op !== 5'h1A) begin errors++; $display("FAIL alu_op got %h exp 1a", alu_op); end
    checks++; if (reg_operand_index !== 4'h3) begin errors++; $display("FAIL alu_operand_index got %h exp 3", reg_operand_index); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL alu_bus_req got %b exp 0", bus_req); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_out_valid_clear got %b exp 0", out_valid); end
  endtask
  task automatic test_load;
    in_valid = 1'b1; in_instruction = 32'h0C12_0000;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus_req, bus_read, bus_write, fetch_block} !== 4'b1101) begin errors++; $display("FAIL load_bus cycle %0d got %b exp 1101", i, {bus_req, bus_read, bus_write, fetch_block}); end
      checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL load_stall cycle %0d got %b exp 00", i, {in_ready, out_valid}); end
      if (i == 2) bus_ack = 1'b1;
      @(negedge clock);
    end
    bus_ack = 1'b0;
    checks++; if ({bus_width, reg_address_index, reg_data_index} !== 10'b10_0010_0001) begin errors++; $display("FAIL load_fields got %b exp 1000100001", {bus_width, reg_address_index, reg_data_index}); end
    checks++; if (alu_op !== 5'h1A) begin errors++; $display("FAIL load_alu_op_hold got %h exp 1a", alu_op); end
    checks++; if ({bus_req, bus_read, fetch_block} !== 3'b000) begin errors++; $display("FAIL load_bus_release got %b exp 000", {bus_req, bus_read, fetch_block}); end
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0C12_0000) begin errors++; $display("FAIL load_out got %b %h exp 1 0c120000", out_valid, out_instruction); end
    @(negedge clock);
  endtask
  task automatic test_store_timeout;
    in_valid = 1'b1; in_instruction = 32'h1234_5678;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus_write, bus_read, timeout_error} !== 3'b100) begin errors++; $display("FAIL store_bus cycle %0d got %b exp 100", i, {bus_write, bus_read, timeout_error}); end
      @(negedge clock);
    end
    checks++; if ({bus_write, fetch_block, timeout_error} !== 3'b001) begin errors++; $display("FAIL store_timeout got %b exp 001", {bus_write, fetch_block, timeout_error}); end
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0) begin errors++; $display("FAIL store_nop got %b %h exp 1 00000000", out_valid, out_instruction); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL store_in_ready got %b exp 1", in_ready); end
    checks++; if (bus_width !== 2'b01) begin errors++; $display("FAIL store_width got %b exp 01", bus_width); end
    @(negedge clock);
    checks++; if ({timeout_error, out_valid} !== 2'b00) begin errors++; $display("FAIL store_pulse_end got %b exp 00", {timeout_error, out_valid}); end
  endtask
  task automatic test_back_to_back;
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = 32'h2000_1100;
    @(negedge clock);
    in_instruction = 32'h1800_2200;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h2000_1100) begin errors++; $display("FAIL b2b_hold cycle %0d got %b %h exp 1 20001100", i, out_valid, out_instruction); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b exp 0", i, in_ready); end
      @(negedge clock);
    end
    checks++; if (out_instruction !== 32'h2000_1100 || alu_op !== 5'h11) begin errors++; $display("FAIL b2b_still_first got %h %h exp 20001100 11", out_instruction, alu_op); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_release got %b exp 1", in_ready); end
    @(negedge clock);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h1800_2200) begin errors++; $display("FAIL b2b_second got %b %h exp 1 18002200", out_valid, out_instruction); end
    checks++; if (alu_op !== 5'h02) begin errors++; $display("FAIL b2b_alum_op got %h exp 02", alu_op); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b exp 0", out_valid); end
  endtask
  task automatic test_ack_on_timeout;
    in_valid = 1'b1; in_instruction = 32'h0A00_0000;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_ack = 1'b1;
      @(negedge clock);
    end
    bus_ack = 1'b0;
    checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL ackto_error got %b exp 0", timeout_error); end
    checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0A00_0000) begin errors++; $display("FAIL ackto_out got %b %h exp 1 0a000000", out_valid, out_instruction); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ackto_bus_req got %b exp 0", bus_req); end
    @(negedge clock);
    checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL ackto_error_late got %b exp 0", timeout_error); end
  endtask
  task automatic test_reset_in_bus;
    in_valid = 1'b1; in_instruction = 32'h1234_5678;
    @(negedge clock);
    in_valid = 1'b0;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_bus_entered got %b exp 1", bus_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus_req, fetch_block, bus_write} !== 3'b000) begin errors++; $display("FAIL rst_async_drop got %b exp 000", {bus_req, fetch_block, bus_write}); end
    checks++; if (out_valid !== 1'b0 || out_instruction !== 32'h0) begin errors++; $display("FAIL rst_out got %b %h exp 0 00000000", out_valid, out_instruction); end
    @(negedge clock);
    reset = 1'b0;
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0;
    checks++; if ({out_valid, bus_req, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_discard got %b exp 001", {out_valid, bus_req, in_ready}); end
  endtask
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store_timeout;
    test_back_to_back;
    test_ack_on_timeout;
    test_reset_in_bus;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage_issue.md
# memory_stage_issue

Parametrised first memory pipeline stage, the successor to the original single-cycle memory stage. It accepts decoded instructions over a valid/ready handshake and extracts register indices, ALU operation and memory cycle width. For LOAD/STORE it runs a request/acknowledge bus cycle with a configurable timeout. It then forwards the instruction to the next stage over a second valid/ready handshake, holding fetch off while it owns the bus.

## Interface
- OPC_NOP, 5'h00, opcode of the NOP instruction; the substituted instruction is {OPC_NOP, 27'h0}
- OPC_LOAD, 5'h01, opcode that triggers a bus read
- OPC_STORE, 5'h02, opcode that triggers a bus write
- OPC_ALUM, 5'h03, ALU-with-memory opcode; alu_op MSB is 0
- OPC_ALU, 5'h04, ALU register opcode; alu_op MSB is 1
- TIMEOUT_CYCLES, 16, bus cycles to wait for bus_ack before aborting; 0 disables the timeout
- clock  in  1  stage clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_instruction  in  32  fields: opcode [31:27], width [26:25], data index [23:20], address index [19:16], ALU op [15:12], operand index [11:8]
- out_valid  out  1  out_instruction valid for the next stage
- out_ready  in  1  next stage accepts out_instruction
- out_instruction  out  32  forwarded instruction, or NOP after a timeout
- bus_req  out  1  memory cycle request
- bus_read  out  1  request is a read
- bus_write  out  1  request is a write
- bus_width  out  2  cycle width, copied from instruction [26:25]
- bus_ack  in  1  memory cycle completed
- fetch_block  out  1  high while this stage owns the bus; instruction fetch must not run
- timeout_error  out  1  one-cycle pulse when a bus cycle is aborted
- reg_address_index  out  4  copied from instruction [19:16]
- reg_data_index  out  4  copied from instruction [23:20]
- reg_operand_index  out  4  copied from instruction [11:8]
- alu_op  out  5  {MSB, instruction [15:12]}

## Operation
- States are IDLE and BUS.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept occurs on an edge where in_valid && in_ready. On accept:
  - register indices and bus_width are latched.
  - alu_op is latched only for ALU/ALUM; otherwise it holds its previous value.
- Accept of LOAD or STORE:
  - go to BUS; bus_req=1 and fetch_block=1.
  - bus_read=1 for LOAD, bus_write=1 for STORE; the other one is 0.
  - the timeout counter clears to 0.
- Accept of any other opcode: stay in IDLE; out_instruction=in_instruction and out_valid=1.
- In BUS, bus_ack sampled high:
  - bus_req, bus_read, bus_write and fetch_block go to 0.
  - out_instruction=latched instruction, out_valid=1, state goes to IDLE.
- In BUS, no ack: the counter increments. When it reaches TIMEOUT_CYCLES, and TIMEOUT_CYCLES != 0:
  - the bus cycle is abandoned as on ack.
  - out_instruction={OPC_NOP,27'h0}, out_valid=1, timeout_error pulses for one cycle.
- An ack on the same edge the timeout would fire wins; no error is raised.
- bus_ack outside BUS is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1) with a minimum of 1, and it saturates; there is no wrap.
- out_valid clears on an edge where out_ready is high and no new instruction loads; a simultaneous new load keeps it high.
- bus_width 2'b11 is passed through unchanged; it is not checked.

## Timing
- Reset values:
  - state IDLE.
  - out_valid, bus_req, bus_read, bus_write, fetch_block and timeout_error are 0.
  - bus_width, all indices and alu_op are 0.
  - out_instruction is {OPC_NOP,27'h0} and the counter is 0.
- Reset mid-BUS drops bus_req and fetch_block asynchronously; the pending instruction is discarded.
- Non-memory latency: accept at edge N gives out_valid after edge N. Throughput is one instruction per cycle while out_ready=1.
- Memory latency: accept at edge N raises bus_req after N. An ack sampled at edge M gives out_valid after M, so the minimum is 2 edges.
- Timeout: with bus_req raised at edge N and no ack, timeout_error is high after edge N+TIMEOUT_CYCLES and low after the next edge.
- in_ready is 0 throughout BUS, and 0 while out_valid && !out_ready.

## Test plan
- ALU instruction 32'h2000_A300 (opcode 4, ALU op 4'hA, operand index 3), out_ready=1 -> out_valid next cycle with the same word, alu_op=5'h1A, reg_operand_index=3.
- LOAD 32'h0C12_0000 (opcode 1, width 2'b10, address index 2, data index 1), ack 3 cycles later -> bus_req/bus_read/fetch_block high 3 cycles, bus_width=2'b10, reg_address_index=2, reg_data_index=1, then out_valid with the LOAD word.
- STORE with no ack, TIMEOUT_CYCLES=4 -> bus_write high 4 cycles, timeout_error pulses once, out_instruction=32'h0, in_ready returns.
- Back-to-back ALU instructions with out_ready low 2 cycles -> the first output is held and in_ready=0 while stalled; no instruction is lost or duplicated.
- Ack arriving on the timeout edge -> no timeout_error; the instruction is forwarded unchanged.
- Reset asserted in BUS -> bus_req and fetch_block drop immediately; out_valid=0 and out_instruction=32'h0.
